pulse_hold_checker: RTL and testbench

- Synthesizable, multi-channel hold-time protocol checker.
- Implements in RTL the rule "on a rising edge of sig, sig stays high for MIN_HIGH consecutive samples", with reset/enable abort semantics.
- Generalised to NUM_CH channels, programmable hold length, per-channel enable, verdict pulses, sticky failure flags and saturating pass/fail counters.
- Sits beside the protocol blocks as an on-chip monitor; its verdicts feed status registers and debug.

---
 rtl/pulse_hold_checker.sv | 90 +++++++++
 tb/tb_pulse_hold_checker.sv | 116 +++++++++++
 2 files changed

// File: rtl/pulse_hold_checker.sv
// pulse_hold_checker: per-channel check that sig stays high for MIN_HIGH samples after each rise, with verdict pulses, sticky flags and saturating counters
module pulse_hold_checker #(
    parameter int NUM_CH   = 4,
    parameter int MIN_HIGH = 2,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] sig,
    input  logic [NUM_CH-1:0] en,
    input  logic              clr_sticky,
    output logic [NUM_CH-1:0] pass_pulse,
    output logic [NUM_CH-1:0] fail_pulse,
    output logic [NUM_CH-1:0] fail_sticky,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [NUM_CH-1:0] busy
);
    localparam int HW = $clog2(MIN_HIGH + 1);
    localparam int PW = $clog2(NUM_CH + 1);
    localparam int SW = CNT_W + PW;
    localparam logic [SW-1:0] CNT_MAX = {{PW{1'b0}}, {CNT_W{1'b1}}};
    typedef enum logic {IDLE, CHECK} state_t;
    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [HW-1:0]     hold_q  [NUM_CH];
    logic [HW-1:0]     hold_d  [NUM_CH];
    logic [NUM_CH-1:0] sig_prev, rise, pass_d, fail_d;
    logic [PW-1:0]     pass_n, fail_n;
    logic [SW-1:0]     pass_sum, fail_sum;
    assign rise = sig & ~sig_prev & en;
    always_comb begin
        pass_d = '0;
        fail_d = '0;
        pass_n = '0;
        fail_n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            if (state_q[i] == IDLE) begin
                if (rise[i]) begin
                    pass_d[i]  = MIN_HIGH == 1;
                    state_d[i] = MIN_HIGH == 1 ? IDLE : CHECK;
                    hold_d[i]  = HW'(1);
                end
            end else if (sig[i]) begin
                hold_d[i]  = hold_q[i] + 1'b1;
                pass_d[i]  = hold_d[i] == HW'(MIN_HIGH);
                state_d[i] = pass_d[i] ? IDLE : CHECK;
            end else begin
                fail_d[i]  = 1'b1;
                state_d[i] = IDLE;
            end
            // abort outranks any verdict decided on the same sample
            if (reset || !en[i]) begin
                state_d[i] = IDLE;
                hold_d[i]  = '0;
                pass_d[i]  = 1'b0;
                fail_d[i]  = 1'b0;
            end
            pass_n = pass_n + PW'(pass_d[i]);
            fail_n = fail_n + PW'(fail_d[i]);
        end
        pass_sum = SW'(pass_cnt) + SW'(pass_n);
        fail_sum = SW'(fail_cnt) + SW'(fail_n);
    end
    always_ff @(posedge clk) begin
        sig_prev <= sig;
        for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= reset ? IDLE : state_d[i];
            hold_q[i]  <= reset ? '0 : hold_d[i];
        end
        if (reset) begin
            pass_pulse  <= '0;
            fail_pulse  <= '0;
            fail_sticky <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
        end else begin
            pass_pulse  <= pass_d;
            fail_pulse  <= fail_d;
            fail_sticky <= (fail_sticky & ~{NUM_CH{clr_sticky}}) | fail_d;
            pass_cnt    <= pass_sum > CNT_MAX ? CNT_MAX[CNT_W-1:0] : pass_sum[CNT_W-1:0];
            fail_cnt    <= fail_sum > CNT_MAX ? CNT_MAX[CNT_W-1:0] : fail_sum[CNT_W-1:0];
        end
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_busy
        assign busy[g] = state_q[g] == CHECK;
    end
endmodule

// File: tb/tb_pulse_hold_checker.sv
// tb_pulse_hold_checker: vector table plus hand-written corner sequences, two DUTs (8-bit and 2-bit counters) on shared inputs
module tb_pulse_hold_checker;
    logic       clk = 1'b0;
    logic       reset, clr_sticky;
    logic [1:0] sig, en;
    logic [1:0] pass_pulse, fail_pulse, fail_sticky, busy;
    logic [7:0] pass_cnt, fail_cnt;
    logic [1:0] pp2, fp2, st2, bz2, pc2, fc2;
    logic       chk2 = 1'b0;
    int         checks = 0, errors = 0;
    typedef struct {
        logic       rst;
        logic [1:0] en, sig;
        logic       clr;
        logic [1:0] pp, fp, st;
        logic [7:0] pc, fc;
        logic [1:0] bz;
    } vec_t;
    vec_t tbl [29];
    vec_t sb [$];
    always #5 clk = ~clk;
    pulse_hold_checker #(.NUM_CH(2), .MIN_HIGH(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .sig(sig), .en(en), .clr_sticky(clr_sticky),
        .pass_pulse(pass_pulse), .fail_pulse(fail_pulse), .fail_sticky(fail_sticky),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .busy(busy)
    );
    pulse_hold_checker #(.NUM_CH(2), .MIN_HIGH(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .sig(sig), .en(en), .clr_sticky(clr_sticky),
        .pass_pulse(pp2), .fail_pulse(fp2), .fail_sticky(st2),
        .pass_cnt(pc2), .fail_cnt(fc2), .busy(bz2)
    );
    function automatic vec_t mk(input logic rst, input logic [1:0] e, input logic [1:0] s, input logic c,
                                input logic [1:0] pp, input logic [1:0] fp, input logic [1:0] st,
                                input logic [7:0] pc, input logic [7:0] fc, input logic [1:0] bz);
        vec_t v;
        v.rst = rst; v.en = e; v.sig = s; v.clr = c;
        v.pp = pp; v.fp = fp; v.st = st; v.pc = pc; v.fc = fc; v.bz = bz;
        return v;
    endfunction
    function automatic logic [1:0] sat2(input logic [7:0] x);
        return x > 8'd3 ? 2'd3 : x[1:0];
    endfunction
    task automatic apply(input vec_t v);
        vec_t e;
        reset = v.rst; en = v.en; sig = v.sig; clr_sticky = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({pass_pulse, fail_pulse, fail_sticky, pass_cnt, fail_cnt, busy} !== {e.pp, e.fp, e.st, e.pc, e.fc, e.bz}) begin
            errors++;
            $display("FAIL vec rst=%b en=%b sig=%b clr=%b: got pp=%b fp=%b st=%b pc=%0d fc=%0d busy=%b, expected pp=%b fp=%b st=%b pc=%0d fc=%0d busy=%b",
                     e.rst, e.en, e.sig, e.clr, pass_pulse, fail_pulse, fail_sticky, pass_cnt, fail_cnt, busy,
                     e.pp, e.fp, e.st, e.pc, e.fc, e.bz);
        end
        if (chk2) begin
            checks++;
            if ({pp2, fp2, st2, pc2, fc2, bz2} !== {e.pp, e.fp, e.st, sat2(e.pc), sat2(e.fc), e.bz}) begin
                errors++;
                $display("FAIL cnt2 sig=%b en=%b: got pp=%b fp=%b st=%b pc=%0d fc=%0d busy=%b, expected pp=%b fp=%b st=%b pc=%0d fc=%0d busy=%b",
                         e.sig, e.en, pp2, fp2, st2, pc2, fc2, bz2, e.pp, e.fp, e.st, sat2(e.pc), sat2(e.fc), e.bz);
            end
        end
    endtask
    initial begin
        //           rst en     sig    clr  pp     fp     st     pc     fc     busy
        tbl[0]  = mk(1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00);
        tbl[1]  = mk(1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00);
        tbl[2]  = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00);
        tbl[3]  = mk(0, 2'b11, 2'b01, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b01);
        tbl[4]  = mk(0, 2'b11, 2'b01, 0, 2'b01, 2'b00, 2'b00, 8'd1, 8'd0, 2'b00);
        tbl[5]  = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 2'b00);
        tbl[6]  = mk(0, 2'b11, 2'b01, 0, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 2'b01);
        tbl[7]  = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b01, 2'b01, 8'd1, 8'd1, 2'b00);
        tbl[8]  = mk(0, 2'b11, 2'b00, 1, 2'b00, 2'b00, 2'b00, 8'd1, 8'd1, 2'b00);
        tbl[9]  = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8'd1, 8'd1, 2'b00);
        tbl[10] = mk(0, 2'b11, 2'b01, 0, 2'b00, 2'b00, 2'b00, 8'd1, 8'd1, 2'b01);
        tbl[11] = mk(1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00);
        tbl[12] = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00);
        tbl[13] = mk(1, 2'b11, 2'b10, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00);
        tbl[14] = mk(1, 2'b11, 2'b10, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00);
        tbl[15] = mk(0, 2'b11, 2'b10, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00);
        tbl[16] = mk(0, 2'b11, 2'b10, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00);
        tbl[17] = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00);
        tbl[18] = mk(0, 2'b11, 2'b10, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b10);
        tbl[19] = mk(0, 2'b11, 2'b10, 0, 2'b10, 2'b00, 2'b00, 8'd1, 8'd0, 2'b00);
        tbl[20] = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 2'b00);
        tbl[21] = mk(0, 2'b11, 2'b11, 0, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 2'b11);
        tbl[22] = mk(0, 2'b11, 2'b11, 0, 2'b11, 2'b00, 2'b00, 8'd3, 8'd0, 2'b00);
        tbl[23] = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8'd3, 8'd0, 2'b00);
        tbl[24] = mk(0, 2'b11, 2'b11, 0, 2'b00, 2'b00, 2'b00, 8'd3, 8'd0, 2'b11);
        tbl[25] = mk(0, 2'b11, 2'b10, 0, 2'b10, 2'b01, 2'b01, 8'd4, 8'd1, 2'b00);
        tbl[26] = mk(0, 2'b11, 2'b01, 0, 2'b00, 2'b00, 2'b01, 8'd4, 8'd1, 2'b01);
        tbl[27] = mk(0, 2'b11, 2'b01, 0, 2'b01, 2'b00, 2'b01, 8'd5, 8'd1, 2'b00);
        tbl[28] = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b01, 8'd5, 8'd1, 2'b00);
        for (int i = 0; i < 29; i++) apply(tbl[i]);
        // saturation and fail-beats-clear, checked on both counter widths
        chk2 = 1'b1;
        apply(mk(1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00));
        apply(mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00));
        for (int n = 0; n < 5; n++) begin
            apply(mk(0, 2'b11, 2'b01, n > 0, 2'b00, 2'b00, 2'b00, 8'd0, 8'(n), 2'b01));
            apply(mk(0, 2'b11, 2'b00, n > 0, 2'b00, 2'b01, 2'b01, 8'd0, 8'(n + 1), 2'b00));
        end
        // enable drop on the deciding sample, then enable rising under a held-high level
        apply(mk(0, 2'b11, 2'b01, 0, 2'b00, 2'b00, 2'b01, 8'd0, 8'd5, 2'b01));
        apply(mk(0, 2'b10, 2'b00, 0, 2'b00, 2'b00, 2'b01, 8'd0, 8'd5, 2'b00));
        apply(mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b01, 8'd0, 8'd5, 2'b00));
        apply(mk(0, 2'b10, 2'b01, 0, 2'b00, 2'b00, 2'b01, 8'd0, 8'd5, 2'b00));
        apply(mk(0, 2'b11, 2'b01, 0, 2'b00, 2'b00, 2'b01, 8'd0, 8'd5, 2'b00));
        apply(mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b01, 8'd0, 8'd5, 2'b00));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
